gdu_fill_master: RTL and testbench

Avalon-MM initiator that drives the graphics drawing unit's 12-bit word-addressed slave port, the responder end of the same bus. Given one command (base address, word count, seed data, per-word increment), it issues back-to-back single-word writes to fill or clear GDU RAM regions such as frame/sprite tables. It then reports completion. It sits between the CPU-side command registers and the GDU slave port, so software does not hand-copy words.

---
 rtl/gdu_pkg.sv | 31 +++
 rtl/gdu_seq_gen.sv | 41 ++++
 rtl/gdu_fill_master.sv | 186 ++++++++++++++++++
 tb/tb_gdu_fill_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gdu_pkg.sv
// Shared defaults, FSM state type and latched-command payload for the GDU fill master.
package gdu_pkg;

  localparam int unsigned GDU_ADDR_W = 12;
  localparam int unsigned GDU_DATA_W = 32;
  localparam int unsigned GDU_CNT_W  = 13;
  localparam int unsigned GDU_BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VERIFY,
    ST_FINISH
  } fill_state_e;

  typedef struct packed {
    logic [GDU_ADDR_W-1:0] addr;
    logic [GDU_CNT_W-1:0]  count;
    logic [GDU_DATA_W-1:0] data;
    logic [GDU_DATA_W-1:0] incr;
    logic [GDU_BE_W-1:0]   byte_en;
  } fill_cmd_t;

  // Expand byte enables into a per-bit compare mask.
  function automatic logic [GDU_DATA_W-1:0] be_to_mask(input logic [GDU_BE_W-1:0] be);
    logic [GDU_DATA_W-1:0] m;
    for (int b = 0; b < GDU_BE_W; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

endpackage

// File: rtl/gdu_seq_gen.sv
// Address/data/remaining-count generator shared by the write and verify passes.
module gdu_seq_gen #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 13
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_count,
  input  logic [DATA_W-1:0] incr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              last_c
);

  logic [CNT_W-1:0] remaining;

  // Load wins over advance so a pass can restart on the same edge as the last accept.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      addr      <= '0;
      data      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      data      <= load_data;
      remaining <= load_count;
    end else if (advance) begin
      addr      <= addr + ADDR_W'(1);
      data      <= data + incr;
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign last_c = (remaining == CNT_W'(1));

endmodule

// File: rtl/gdu_fill_master.sv
// GDU fill master: Avalon-MM initiator filling a GDU RAM region from one command.
// Define GDU_FILL_VERIFY_EN to add a read-back verify pass and the VERIFY_ERR output.
module gdu_fill_master
  import gdu_pkg::*;
#(
  parameter int unsigned ADDR_W       = GDU_ADDR_W,
  parameter int unsigned DATA_W       = GDU_DATA_W,
  parameter int unsigned CNT_W        = GDU_CNT_W,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [CNT_W-1:0]  CMD_COUNT,
  input  logic [DATA_W-1:0] CMD_DATA,
  input  logic [DATA_W-1:0] CMD_INCR,
  input  logic [3:0]        CMD_BYTE_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic              AVM_CS,
  output logic              AVM_WRITE,
  output logic              AVM_READ,
  output logic [ADDR_W-1:0] AVM_ADDR,
  output logic [3:0]        AVM_BYTE_EN,
  output logic [DATA_W-1:0] AVM_WRITEDATA,
  input  logic [DATA_W-1:0] AVM_READDATA,
  input  logic              AVM_WAITREQUEST
`ifdef GDU_FILL_VERIFY_EN
  ,
  output logic              VERIFY_ERR
`endif
);

  fill_state_e       state;
  fill_cmd_t         cmd_q;
  logic              start_acc;
  logic              wr_acc;
  logic              seq_load;
  logic              seq_adv;
  logic              seq_last_c;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [CNT_W-1:0]  ld_count;

`ifdef GDU_FILL_VERIFY_EN
  localparam logic [READ_LATENCY-1:0] LAST_ONLY = READ_LATENCY'(1) << (READ_LATENCY - 1);

  logic                    rd_acc;
  logic [READ_LATENCY-1:0] pipe_v;
  logic [DATA_W-1:0]       pipe_d [READ_LATENCY];
  logic [DATA_W-1:0]       cmp_mask;
`endif

  assign start_acc = (state == ST_IDLE) && START;
  assign wr_acc    = (state == ST_WRITE) && !AVM_WAITREQUEST;

  // The first pass loads from the live command; the verify pass reloads from the latched one.
`ifdef GDU_FILL_VERIFY_EN
  assign rd_acc   = (state == ST_VERIFY) && AVM_READ && !AVM_WAITREQUEST;
  assign seq_load = start_acc || (wr_acc && seq_last_c);
  assign seq_adv  = wr_acc || rd_acc;
`else
  assign seq_load = start_acc;
  assign seq_adv  = wr_acc;
`endif
  assign ld_addr  = start_acc ? CMD_ADDR  : ADDR_W'(cmd_q.addr);
  assign ld_data  = start_acc ? CMD_DATA  : DATA_W'(cmd_q.data);
  assign ld_count = start_acc ? CMD_COUNT : CNT_W'(cmd_q.count);

  gdu_seq_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_seq (
    .CLK        (CLK),
    .RESET      (RESET),
    .load       (seq_load),
    .advance    (seq_adv),
    .load_addr  (ld_addr),
    .load_data  (ld_data),
    .load_count (ld_count),
    .incr       (DATA_W'(cmd_q.incr)),
    .addr       (AVM_ADDR),
    .data       (AVM_WRITEDATA),
    .last_c     (seq_last_c)
  );

  // Fill FSM with registered control outputs.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      AVM_CS      <= 1'b0;
      AVM_WRITE   <= 1'b0;
      AVM_READ    <= 1'b0;
      AVM_BYTE_EN <= 4'h0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            cmd_q <= '{addr:    GDU_ADDR_W'(CMD_ADDR),
                       count:   GDU_CNT_W'(CMD_COUNT),
                       data:    GDU_DATA_W'(CMD_DATA),
                       incr:    GDU_DATA_W'(CMD_INCR),
                       byte_en: CMD_BYTE_EN};
            BUSY        <= 1'b1;
            AVM_BYTE_EN <= CMD_BYTE_EN;
            if (CMD_COUNT == '0) begin
              state <= ST_FINISH;
              DONE  <= 1'b1;
            end else begin
              state     <= ST_WRITE;
              AVM_CS    <= 1'b1;
              AVM_WRITE <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (!AVM_WAITREQUEST && seq_last_c) begin
            AVM_WRITE <= 1'b0;
`ifdef GDU_FILL_VERIFY_EN
            AVM_READ <= 1'b1;
            state    <= ST_VERIFY;
`else
            AVM_CS <= 1'b0;
            state  <= ST_FINISH;
            DONE   <= 1'b1;
`endif
          end
        end
`ifdef GDU_FILL_VERIFY_EN
        ST_VERIFY: begin
          if (rd_acc && seq_last_c) begin
            AVM_CS   <= 1'b0;
            AVM_READ <= 1'b0;
          end
          // All reads issued and only the final compare is left in flight.
          if (!AVM_READ && (pipe_v == LAST_ONLY)) begin
            state <= ST_FINISH;
            DONE  <= 1'b1;
          end
        end
`endif
        ST_FINISH: begin
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef GDU_FILL_VERIFY_EN
  assign cmp_mask = DATA_W'(be_to_mask(cmd_q.byte_en));

  // Expected-data delay line aligned with the slave read latency; sticky mismatch flag.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pipe_v     <= '0;
      VERIFY_ERR <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= rd_acc;
      pipe_d[0] <= AVM_WRITEDATA;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      if (start_acc) begin
        VERIFY_ERR <= 1'b0;
      end else if (pipe_v[READ_LATENCY-1] &&
                   (((AVM_READDATA ^ pipe_d[READ_LATENCY-1]) & cmp_mask) != '0)) begin
        VERIFY_ERR <= 1'b1;
      end
    end
  end
`else
  logic unused_c;
  assign unused_c = ^{AVM_READDATA, cmd_q.byte_en, 32'(READ_LATENCY)};
`endif

endmodule

// File: tb/tb_gdu_fill_master.sv
// Directed self-checking bench for gdu_fill_master with a small gdu_ram slave model.
`timescale 1ns/1ps
module tb_gdu_fill_master;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic [11:0] CMD_ADDR = '0;
  logic [12:0] CMD_COUNT = '0;
  logic [31:0] CMD_DATA = '0;
  logic [31:0] CMD_INCR = '0;
  logic [3:0]  CMD_BYTE_EN = '0;
  logic        BUSY, DONE, AVM_CS, AVM_WRITE, AVM_READ;
  logic [11:0] AVM_ADDR;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;
  logic [31:0] AVM_READDATA;
  logic        AVM_WAITREQUEST = 1'b0;
`ifdef GDU_FILL_VERIFY_EN
  logic        VERIFY_ERR;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  gdu_fill_master dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .START           (START),
    .CMD_ADDR        (CMD_ADDR),
    .CMD_COUNT       (CMD_COUNT),
    .CMD_DATA        (CMD_DATA),
    .CMD_INCR        (CMD_INCR),
    .CMD_BYTE_EN     (CMD_BYTE_EN),
    .BUSY            (BUSY),
    .DONE            (DONE),
    .AVM_CS          (AVM_CS),
    .AVM_WRITE       (AVM_WRITE),
    .AVM_READ        (AVM_READ),
    .AVM_ADDR        (AVM_ADDR),
    .AVM_BYTE_EN     (AVM_BYTE_EN),
    .AVM_WRITEDATA   (AVM_WRITEDATA),
    .AVM_READDATA    (AVM_READDATA),
    .AVM_WAITREQUEST (AVM_WAITREQUEST)
`ifdef GDU_FILL_VERIFY_EN
    ,
    .VERIFY_ERR      (VERIFY_ERR)
`endif
  );

  always #5 CLK = ~CLK;

  // gdu_ram model: byte-enabled writes, one-cycle read latency, plus a backdoor write port.
  logic [31:0] mem [4096];
  logic [31:0] rd_q = '0;
  logic        bd_en = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  always @(posedge CLK) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    if (AVM_CS && AVM_WRITE && !AVM_WAITREQUEST)
      for (int b = 0; b < 4; b++)
        if (AVM_BYTE_EN[b]) mem[AVM_ADDR][b*8 +: 8] <= AVM_WRITEDATA[b*8 +: 8];
    if (AVM_CS && AVM_READ && !AVM_WAITREQUEST) rd_q <= mem[AVM_ADDR];
  end
  assign AVM_READDATA = rd_q;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_wr(input string tag, input logic [11:0] a, input logic [31:0] d);
    check_vec({tag, "_cs"},   32'(AVM_CS),    32'd1);
    check_vec({tag, "_wr"},   32'(AVM_WRITE), 32'd1);
    check_vec({tag, "_rd"},   32'(AVM_READ),  32'd0);
    check_vec({tag, "_addr"}, 32'(AVM_ADDR),  32'(a));
    check_vec({tag, "_data"}, AVM_WRITEDATA,  d);
    check_vec({tag, "_busy"}, 32'(BUSY),      32'd1);
    check_vec({tag, "_done"}, 32'(DONE),      32'd0);
  endtask

  task automatic expect_done(input string tag);
    check_vec({tag, "_done"}, 32'(DONE),      32'd1);
    check_vec({tag, "_busy"}, 32'(BUSY),      32'd1);
    check_vec({tag, "_cs"},   32'(AVM_CS),    32'd0);
    check_vec({tag, "_wr"},   32'(AVM_WRITE), 32'd0);
    check_vec({tag, "_rd"},   32'(AVM_READ),  32'd0);
  endtask

  task automatic expect_idle(input string tag);
    check_vec({tag, "_done"}, 32'(DONE),      32'd0);
    check_vec({tag, "_busy"}, 32'(BUSY),      32'd0);
    check_vec({tag, "_cs"},   32'(AVM_CS),    32'd0);
    check_vec({tag, "_wr"},   32'(AVM_WRITE), 32'd0);
    check_vec({tag, "_rd"},   32'(AVM_READ),  32'd0);
  endtask

  task automatic expect_reset(input string tag);
    expect_idle(tag);
    check_vec({tag, "_addr"}, 32'(AVM_ADDR),    32'd0);
    check_vec({tag, "_data"}, AVM_WRITEDATA,    32'd0);
    check_vec({tag, "_be"},   32'(AVM_BYTE_EN), 32'd0);
  endtask

  // Pulse START for one cycle with the given command; returns in the cycle after START.
  task automatic issue(input logic [11:0] a, input logic [12:0] n, input logic [31:0] d,
                       input logic [31:0] inc, input logic [3:0] be);
    CMD_ADDR    = a;
    CMD_COUNT   = n;
    CMD_DATA    = d;
    CMD_INCR    = inc;
    CMD_BYTE_EN = be;
    START       = 1'b1;
    tick();
    START       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    RESET = 1'b0;
    tick();
    tick();
    expect_reset("rst");
    RESET = 1'b1;
    tick();
    expect_idle("rst_rel");

    // Basic 4-word fill
    issue(12'h010, 13'd4, 32'h100, 32'd1, 4'hF);
    expect_wr("f4w0", 12'h010, 32'h100);
    check_vec("f4_be", 32'(AVM_BYTE_EN), 32'hF);
    tick();
    expect_wr("f4w1", 12'h011, 32'h101);
    tick();
    expect_wr("f4w2", 12'h012, 32'h102);
    tick();
    expect_wr("f4w3", 12'h013, 32'h103);
    tick();
    expect_done("f4");
    check_vec("f4_mem3", mem[12'h013], 32'h103);
    tick();
    expect_idle("f4_idle");

    // Address and data wrap
    issue(12'hFFE, 13'd3, 32'h0, 32'hFFFF_FFFF, 4'hF);
    expect_wr("wrw0", 12'hFFE, 32'h0000_0000);
    tick();
    expect_wr("wrw1", 12'hFFF, 32'hFFFF_FFFF);
    tick();
    expect_wr("wrw2", 12'h000, 32'hFFFF_FFFE);
    tick();
    expect_done("wr");
    check_vec("wr_mem0", mem[12'h000], 32'hFFFF_FFFE);
    tick();
    expect_idle("wr_idle");

    // Zero-length command
    issue(12'h050, 13'd0, 32'h1234, 32'd1, 4'hF);
    expect_done("z");
    tick();
    expect_idle("z_idle");

    // Wait states on word 2 of 3, plus an ignored START while busy
    issue(12'h100, 13'd3, 32'h5, 32'h10, 4'h3);
    expect_wr("ws0", 12'h100, 32'h05);
    check_vec("ws_be", 32'(AVM_BYTE_EN), 32'h3);
    tick();
    AVM_WAITREQUEST = 1'b1;
    expect_wr("ws1a", 12'h101, 32'h15);
    tick();
    expect_wr("ws1b", 12'h101, 32'h15);
    CMD_ADDR  = 12'h3AA;
    CMD_COUNT = 13'd1;
    START     = 1'b1;
    tick();
    START = 1'b0;
    expect_wr("ws1c", 12'h101, 32'h15);
    check_vec("ws_be_hold", 32'(AVM_BYTE_EN), 32'h3);
    tick();
    AVM_WAITREQUEST = 1'b0;
    expect_wr("ws1d", 12'h101, 32'h15);
    tick();
    expect_wr("ws2", 12'h102, 32'h25);
    tick();
    expect_done("ws");
    check_vec("ws_mem1", mem[12'h101], 32'h15);
    check_vec("ws_mem2", mem[12'h102], 32'h25);
    tick();
    expect_idle("ws_idle");
    tick();
    expect_idle("ws_nostart");

    // Reset at word 5 of 10, then a normal fill
    issue(12'h200, 13'd10, 32'h0, 32'd1, 4'hF);
    expect_wr("rm0", 12'h200, 32'h0);
    tick();
    expect_wr("rm1", 12'h201, 32'h1);
    tick();
    expect_wr("rm2", 12'h202, 32'h2);
    tick();
    expect_wr("rm3", 12'h203, 32'h3);
    tick();
    expect_wr("rm4", 12'h204, 32'h4);
    RESET = 1'b0;
    tick();
    expect_reset("rm_rst");
    RESET = 1'b1;
    tick();
    expect_idle("rm_after1");
    tick();
    expect_idle("rm_after2");
    issue(12'h300, 13'd2, 32'h7, 32'd2, 4'hF);
    expect_wr("rn0", 12'h300, 32'h7);
    tick();
    expect_wr("rn1", 12'h301, 32'h9);
    tick();
    expect_done("rn");
    tick();
    expect_idle("rn_idle");

`ifdef GDU_FILL_VERIFY_EN
    begin
      int c;
      // 8-word fill, word 3 corrupted through the backdoor before the verify pass
      issue(12'h040, 13'd8, 32'h1000, 32'h11, 4'hF);
      expect_wr("v1w0", 12'h040, 32'h1000);
      check_vec("v1_err_clr", 32'(VERIFY_ERR), 32'd0);
      tick();
      expect_wr("v1w1", 12'h041, 32'h1011);
      tick();
      expect_wr("v1w2", 12'h042, 32'h1022);
      tick();
      expect_wr("v1w3", 12'h043, 32'h1033);
      tick();
      expect_wr("v1w4", 12'h044, 32'h1044);
      bd_en   = 1'b1;
      bd_addr = 12'h043;
      bd_data = 32'hDEAD_0000;
      tick();
      bd_en = 1'b0;
      expect_wr("v1w5", 12'h045, 32'h1055);
      tick();
      expect_wr("v1w6", 12'h046, 32'h1066);
      tick();
      expect_wr("v1w7", 12'h047, 32'h1077);
      tick();
      check_vec("v1_rd", 32'(AVM_READ), 32'd1);
      check_vec("v1_rd_wr", 32'(AVM_WRITE), 32'd0);
      check_vec("v1_rd_addr", 32'(AVM_ADDR), 32'h040);
      c = 9;
      while (!DONE && c < 40) begin
        tick();
        c++;
      end
      check_vec("v1_done_cyc", 32'(c), 32'd18);
      check_vec("v1_err", 32'(VERIFY_ERR), 32'd1);
      tick();
      expect_idle("v1_idle");
      check_vec("v1_err_sticky", 32'(VERIFY_ERR), 32'd1);

      // Clean rerun rewrites word 3 and must verify without error
      issue(12'h040, 13'd8, 32'h1000, 32'h11, 4'hF);
      check_vec("v2_err_clr", 32'(VERIFY_ERR), 32'd0);
      c = 1;
      while (!DONE && c < 40) begin
        tick();
        c++;
      end
      check_vec("v2_done_cyc", 32'(c), 32'd18);
      check_vec("v2_err", 32'(VERIFY_ERR), 32'd0);
      tick();
      expect_idle("v2_idle");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
